// File: rtl/jpeg_stream_reader_if.sv
// rtl/jpeg_stream_reader_if.sv - byte input, bit window, consume and marker signals of the JPEG stream reader
interface jpeg_stream_reader_if #(
    parameter int WINDOW_WIDTH = 32,
    parameter int MAX_CONSUME  = 16
);
    logic [7:0]                          in_data;
    logic                                in_valid;
    logic                                in_ready;
    logic [WINDOW_WIDTH-1:0]             win_data;
    logic [$clog2(WINDOW_WIDTH+1)-1:0]   win_bits;
    logic                                consume_valid;
    logic [$clog2(MAX_CONSUME+1)-1:0]    consume_len;
    logic                                marker_valid;
    logic [7:0]                          marker_code;
    logic                                marker_ack;
    logic                                err;

    modport master (
        output in_data, in_valid, consume_valid, consume_len, marker_ack,
        input  in_ready, win_data, win_bits, marker_valid, marker_code, err
    );

    modport slave (
        input  in_data, in_valid, consume_valid, consume_len, marker_ack,
        output in_ready, win_data, win_bits, marker_valid, marker_code, err
    );
endinterface

// File: rtl/jpeg_stream_reader.sv
// rtl/jpeg_stream_reader.sv - JPEG entropy byte stream to left-aligned bit window; optional JPEG_STREAM_STATS_EN counters
module jpeg_stream_reader #(
    parameter int WINDOW_WIDTH = 32,
    parameter int MAX_CONSUME  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jpeg_stream_reader_if.slave   bus
`ifdef JPEG_STREAM_STATS_EN
    ,
    output logic [31:0]           stat_bytes,
    output logic [15:0]           stat_stuffed
`endif
);
    localparam int BW = $clog2(WINDOW_WIDTH + 1);
    localparam int CW = $clog2(MAX_CONSUME + 1);

    typedef enum logic [1:0] {S_DATA, S_FF, S_MARKER} state_t;

    state_t                  state, state_n;
    logic [WINDOW_WIDTH-1:0] win_q, win_n, shifted;
    logic [BW-1:0]           bits_q, bits_n, rem_bits;
    logic                    in_ready_q, marker_valid_q, err_q;
    logic [7:0]              marker_code_q;
    logic                    accept, ack, consume_ok, bad_consume;
    logic                    append_en, marker_hit, stuffed;
    logic [7:0]              append_byte;
    logic [CW-1:0]           len;

    assign len              = bus.consume_len;
    assign bus.in_ready     = in_ready_q;
    assign bus.win_data     = win_q;
    assign bus.win_bits     = bits_q;
    assign bus.marker_valid = marker_valid_q;
    assign bus.marker_code  = marker_code_q;
    assign bus.err          = err_q;

    always_comb begin
        accept      = bus.in_valid && in_ready_q;
        ack         = bus.marker_ack && (state == S_MARKER);
        consume_ok  = bus.consume_valid && (len != '0) &&
                      (int'(len) <= MAX_CONSUME) && (int'(len) <= int'(bits_q));
        // An acked marker flushes the window, so a concurrent consume is moot rather than illegal
        bad_consume = bus.consume_valid && !consume_ok && !ack;

        shifted  = consume_ok ? (win_q << len) : win_q;
        rem_bits = consume_ok ? (bits_q - BW'(len)) : bits_q;

        state_n     = state;
        append_en   = 1'b0;
        append_byte = bus.in_data;
        marker_hit  = 1'b0;
        stuffed     = 1'b0;
        if (accept) begin
            case (state)
                S_DATA: begin
                    if (bus.in_data == 8'hFF) state_n = S_FF;
                    else                      append_en = 1'b1;
                end
                S_FF: begin
                    if (bus.in_data == 8'h00) begin
                        append_en   = 1'b1;
                        append_byte = 8'hFF;
                        stuffed     = 1'b1;
                        state_n     = S_DATA;
                    end else if (bus.in_data != 8'hFF) begin
                        marker_hit = 1'b1;
                        state_n    = S_MARKER;
                    end
                end
                default: ;
            endcase
        end

        // The new byte lands directly behind whatever bits survive this cycle's consume
        win_n  = shifted | (append_en ?
                 ({append_byte, {(WINDOW_WIDTH-8){1'b0}}} >> rem_bits) : '0);
        bits_n = rem_bits + (append_en ? BW'(8) : BW'(0));

        if (ack) begin
            win_n   = '0;
            bits_n  = '0;
            state_n = S_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_DATA;
            win_q          <= '0;
            bits_q         <= '0;
            in_ready_q     <= 1'b0;
            marker_valid_q <= 1'b0;
            marker_code_q  <= 8'h00;
            err_q          <= 1'b0;
        end else begin
            state      <= state_n;
            win_q      <= win_n;
            bits_q     <= bits_n;
            in_ready_q <= (state_n != S_MARKER) && (bits_n <= BW'(WINDOW_WIDTH - 8));
            if (marker_hit) begin
                marker_valid_q <= 1'b1;
                marker_code_q  <= bus.in_data;
            end else if (ack) begin
                marker_valid_q <= 1'b0;
            end
            if (bad_consume) err_q <= 1'b1;
        end
    end

`ifdef JPEG_STREAM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_bytes   <= '0;
            stat_stuffed <= '0;
        end else begin
            if (accept) stat_bytes <= stat_bytes + 32'd1;
            if (stuffed && (stat_stuffed != 16'hFFFF)) stat_stuffed <= stat_stuffed + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_jpeg_stream_reader.sv
// tb/tb_jpeg_stream_reader.sv - bit-queue reference model plus directed vectors for jpeg_stream_reader
module tb_jpeg_stream_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jpeg_stream_reader_if #(.WINDOW_WIDTH(32), .MAX_CONSUME(16)) bus ();

`ifdef JPEG_STREAM_STATS_EN
    logic [31:0] stat_bytes;
    logic [15:0] stat_stuffed;
    jpeg_stream_reader #(.WINDOW_WIDTH(32), .MAX_CONSUME(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .stat_bytes(stat_bytes), .stat_stuffed(stat_stuffed));
`else
    jpeg_stream_reader #(.WINDOW_WIDTH(32), .MAX_CONSUME(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the window is simply the queue of stream bits still owed to the decoder
    bit          mq[$];
    bit          m_ff, m_mark, m_err, m_rdy;
    logic [7:0]  m_code;
    int unsigned m_bytes;
    logic [15:0] m_stuf;

    task automatic push8(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
    endtask

    function automatic logic [31:0] exp_win();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) if (i < mq.size()) r[31-i] = mq[i];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ff = 0; m_mark = 0; m_err = 0; m_rdy = 0;
            m_code = 8'h00; m_bytes = 0; m_stuf = 16'h0;
        end else begin
            bit acc;
            int n;
            acc = bus.in_valid && m_rdy;
            n   = int'(bus.consume_len);
            if (bus.marker_ack && m_mark) begin
                mq.delete();
                m_mark = 0;
            end else if (bus.consume_valid) begin
                if (n >= 1 && n <= 16 && n <= mq.size()) repeat (n) void'(mq.pop_front());
                else m_err = 1;
            end
            if (acc) begin
                m_bytes++;
                if (!m_ff) begin
                    if (bus.in_data == 8'hFF) m_ff = 1;
                    else push8(bus.in_data);
                end else if (bus.in_data == 8'h00) begin
                    push8(8'hFF);
                    m_ff = 0;
                    if (m_stuf != 16'hFFFF) m_stuf++;
                end else if (bus.in_data != 8'hFF) begin
                    m_mark = 1;
                    m_code = bus.in_data;
                    m_ff   = 0;
                end
            end
            m_rdy = !m_mark && (mq.size() <= 24);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp_win_data", 64'(bus.win_data), 64'(exp_win()));
            chk("cmp_win_bits", 64'(bus.win_bits), 64'(mq.size()));
            chk("cmp_in_ready", 64'(bus.in_ready), 64'(m_rdy));
            chk("cmp_marker_valid", 64'(bus.marker_valid), 64'(m_mark));
            chk("cmp_marker_code", 64'(bus.marker_code), 64'(m_code));
            chk("cmp_err", 64'(bus.err), 64'(m_err));
`ifdef JPEG_STREAM_STATS_EN
            chk("cmp_stat_bytes", 64'(stat_bytes), 64'(m_bytes));
            chk("cmp_stat_stuffed", 64'(stat_stuffed), 64'(m_stuf));
`endif
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic cv,
                       input logic [4:0] cl, input logic ack);
        bus.in_valid = v; bus.in_data = d;
        bus.consume_valid = cv; bus.consume_len = cl; bus.marker_ack = ack;
        @(posedge clk); #1;
        bus.in_valid = 0; bus.consume_valid = 0; bus.marker_ack = 0;
    endtask

    task automatic put(input logic [7:0] d);
        cyc(1'b1, d, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        cyc(1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic chk_window(input string name, input logic [31:0] w, input int b);
        chk({name, "_data"}, 64'(bus.win_data), 64'(w));
        chk({name, "_bits"}, 64'(bus.win_bits), 64'(b));
    endtask

    initial begin
        bus.in_valid = 0; bus.in_data = 0; bus.consume_valid = 0;
        bus.consume_len = 0; bus.marker_ack = 0;
        #1;
        chk("rst_win_data", 64'(bus.win_data), 64'h0);
        chk("rst_win_bits", 64'(bus.win_bits), 64'h0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'h0);
        chk("rst_marker", 64'(bus.marker_valid), 64'h0);
        chk("rst_err", 64'(bus.err), 64'h0);
        @(posedge clk); #1;
        rst_n = 1;
        cyc(1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
        chk("ready_after_reset", 64'(bus.in_ready), 64'h1);

        // plain bytes, fill to the ready threshold, max consume
        put(8'h12); chk("seq_bits1", 64'(bus.win_bits), 64'd8);
        put(8'h34); chk("seq_bits2", 64'(bus.win_bits), 64'd16);
        put(8'h56); chk_window("seq3", 32'h12345600, 24);
        chk("ready_at_24", 64'(bus.in_ready), 64'h1);
        put(8'h78); chk_window("seq4", 32'h12345678, 32);
        chk("ready_at_32", 64'(bus.in_ready), 64'h0);
        put(8'h9A); chk_window("full_reject", 32'h12345678, 32);
        cyc(1'b0, 8'h00, 1'b1, 5'd16, 1'b0);
        chk_window("consume16", 32'h56780000, 16);

        // byte stuffing
        do_reset();
        put(8'hAB); put(8'hFF); put(8'h00); put(8'hCD);
        chk_window("stuff", 32'hABFFCD00, 24);
`ifdef JPEG_STREAM_STATS_EN
        chk("stuff_stat_bytes", 64'(stat_bytes), 64'd4);
        chk("stuff_stat_stuffed", 64'(stat_stuffed), 64'd1);
`endif

        // fill bytes
        do_reset();
        put(8'hFF); put(8'hFF); put(8'hFF); put(8'h00);
        chk_window("fill", 32'hFF000000, 8);

        // simultaneous consume and append
        do_reset();
        put(8'hAB); put(8'hCD);
        chk_window("pre_merge", 32'hABCD0000, 16);
        cyc(1'b1, 8'hEF, 1'b1, 5'd4, 1'b0);
        chk_window("merge", 32'hBCDEF000, 20);

        // marker handling
        do_reset();
        put(8'h5A); put(8'hFF); put(8'hD0);
        chk_window("mk", 32'h5A000000, 8);
        chk("mk_valid", 64'(bus.marker_valid), 64'h1);
        chk("mk_code", 64'(bus.marker_code), 64'hD0);
        chk("mk_ready", 64'(bus.in_ready), 64'h0);
        cyc(1'b1, 8'h11, 1'b1, 5'd3, 1'b0);
        chk_window("mk_consume", 32'hD0000000, 5);
        cyc(1'b0, 8'h00, 1'b1, 5'd2, 1'b1);
        chk_window("mk_ack", 32'h0, 0);
        chk("mk_ack_valid", 64'(bus.marker_valid), 64'h0);
        chk("mk_ack_ready", 64'(bus.in_ready), 64'h1);
        chk("mk_ack_noerr", 64'(bus.err), 64'h0);

        // illegal consumes
        put(8'hF8);
        cyc(1'b0, 8'h00, 1'b1, 5'd3, 1'b0);
        chk_window("ill_pre", 32'hC0000000, 5);
        cyc(1'b0, 8'h00, 1'b1, 5'd6, 1'b0);
        chk_window("ill_over", 32'hC0000000, 5);
        chk("ill_err", 64'(bus.err), 64'h1);
        cyc(1'b1, 8'h3C, 1'b1, 5'd0, 1'b0);
        chk_window("ill_zero_append", 32'hC1E00000, 13);
        cyc(1'b0, 8'h00, 1'b1, 5'd17, 1'b0);
        chk_window("ill_max", 32'hC1E00000, 13);
        cyc(1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
        chk_window("stray_ack", 32'hC1E00000, 13);
        chk("err_sticky", 64'(bus.err), 64'h1);

        // asynchronous reset mid-stream with a pending 0xFF
        put(8'hFF);
        #3 rst_n = 0;
        #1;
        chk_window("async_rst", 32'h0, 0);
        chk("async_rst_ready", 64'(bus.in_ready), 64'h0);
        chk("async_rst_err", 64'(bus.err), 64'h0);
        chk("async_rst_marker", 64'(bus.marker_valid), 64'h0);
        @(posedge clk); #1;
        rst_n = 1;
        cyc(1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
        put(8'h00);
        chk_window("post_rst_plain", 32'h00000000, 8);

        cyc(1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
